// File: rtl/dpe_mux_arbiter.sv
// Packet-level weighted round-robin arbiter for the DPE input multiplexer.
// Holds a registered one-hot grant for a whole packet and reports packet beat length.
module dpe_mux_arbiter #(
  parameter int N_REQ    = 5,
  parameter int WEIGHT_W = 4,
  parameter int LEN_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pause,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*WEIGHT_W-1:0]   weight,
  input  logic                        beat_hs,
  input  logic                        beat_last,
  output logic [N_REQ-1:0]            grant,
  output logic                        grant_valid,
  output logic [$clog2(N_REQ)-1:0]    grant_idx,
  output logic                        is_idle,
  output logic                        pkt_done,
  output logic [LEN_W-1:0]            pkt_len
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [IDX_W-1:0]    prev;
  logic [WEIGHT_W-1:0] credit [N_REQ];
  logic [WEIGHT_W-1:0] w_arr  [N_REQ];
  logic [LEN_W-1:0]    cnt;

  logic [IDX_W-1:0]    win;
  logic [IDX_W-1:0]    cand;
  logic                found;
  logic                repeat_win;
  logic [WEIGHT_W-1:0] win_w;
  logic [WEIGHT_W-1:0] load_val;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // The previous owner keeps the bus while it has credit; otherwise scan
  // cyclically from prev+1, with prev itself reached last (k == N_REQ).
  always_comb begin
    win        = prev;
    cand       = prev;
    found      = 1'b0;
    repeat_win = 1'b0;
    if (req[prev] && credit[prev] != '0) begin
      found      = 1'b1;
      repeat_win = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        cand = IDX_W'((32'(prev) + k) % N_REQ);
        if (!found && req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
    win_w    = w_arr[win];
    load_val = (win_w == '0) ? '0 : win_w - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      is_idle     <= 1'b1;
      pkt_done    <= 1'b0;
      pkt_len     <= '0;
      cnt         <= '0;
      prev        <= IDX_W'(N_REQ - 1);
      for (int unsigned i = 0; i < N_REQ; i++) begin
        credit[i] <= '0;
      end
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!pause && found) begin
            state       <= BUSY;
            grant       <= N_REQ'(1) << win;
            grant_valid <= 1'b1;
            grant_idx   <= win;
            is_idle     <= 1'b0;
            cnt         <= '0;
            prev        <= win;
            credit[win] <= repeat_win ? credit[win] - 1'b1 : load_val;
          end
        end
        BUSY: begin
          if (beat_hs) begin
            if (cnt != '1) cnt <= cnt + 1'b1;
            if (beat_last) begin
              pkt_len     <= (cnt == '1) ? cnt : cnt + 1'b1;
              pkt_done    <= 1'b1;
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_idx   <= '0;
              is_idle     <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
